// File: rtl/spi_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : spi_bus_arbiter
// Purpose  : Round-robin arbiter letting two requesters share one SPI mode-0
//            master; each grant runs one full-duplex DATA_W-bit frame.
// Revision : 1.0
// ============================================================================
module spi_bus_arbiter #(
    parameter int DATA_W  = 32,
    parameter int CLK_DIV = 4,
    parameter int CS_GAP  = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              done0,
    output logic              done1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic [1:0]        grant,
    output logic              busy,
    output logic              spi_sclk,
    output logic              spi_mosi,
    output logic              spi_ss_n,
    input  logic              spi_miso
);

    localparam int c_cnt_max = (CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP;
    localparam int c_cnt_w   = $clog2(c_cnt_max + 1);
    localparam int c_bit_w   = $clog2(DATA_W + 1);

    localparam logic [c_cnt_w-1:0] c_div_last = c_cnt_w'(CLK_DIV - 1);
    // GAP plus the single IDLE cycle before the next grant give CS_GAP
    // cycles of spi_ss_n high between back-to-back frames.
    localparam logic [c_cnt_w-1:0] c_gap_last = c_cnt_w'((CS_GAP > 1) ? CS_GAP - 2 : 0);
    localparam logic [c_bit_w-1:0] c_bit_last = c_bit_w'(DATA_W - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_SHIFT = 3'd2,
        ST_HOLD  = 3'd3,
        ST_GAP   = 3'd4
    } state_t;

    state_t              r_state;
    logic [c_cnt_w-1:0]  r_cnt;
    logic [c_bit_w-1:0]  r_bit;
    logic [DATA_W-1:0]   r_tx;
    logic [DATA_W-1:0]   r_rx;
    logic                r_owner;
    logic                r_last;
    logic                w_win;

    // Tie goes to the requester that did not win last time.
    always_comb begin
        w_win = 1'b0;
        if (req0 && req1) begin
            w_win = ~r_last;
        end else begin
            w_win = req1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_bit    <= '0;
            r_tx     <= '0;
            r_rx     <= '0;
            r_owner  <= 1'b0;
            r_last   <= 1'b1;
            grant    <= 2'b00;
            busy     <= 1'b0;
            done0    <= 1'b0;
            done1    <= 1'b0;
            rdata0   <= '0;
            rdata1   <= '0;
            spi_ss_n <= 1'b1;
            spi_sclk <= 1'b0;
            spi_mosi <= 1'b0;
        end else begin
            done0 <= 1'b0;
            done1 <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (req0 || req1) begin
                        r_owner  <= w_win;
                        r_last   <= w_win;
                        grant    <= w_win ? 2'b10 : 2'b01;
                        r_tx     <= w_win ? wdata1 : wdata0;
                        spi_mosi <= w_win ? wdata1[DATA_W-1] : wdata0[DATA_W-1];
                        spi_ss_n <= 1'b0;
                        busy     <= 1'b1;
                        r_cnt    <= '0;
                        r_state  <= ST_SETUP;
                    end
                end

                ST_SETUP: begin
                    if (r_cnt == c_div_last) begin
                        r_cnt    <= '0;
                        r_bit    <= '0;
                        spi_sclk <= 1'b1;
                        r_rx     <= {r_rx[DATA_W-2:0], spi_miso};
                        r_state  <= ST_SHIFT;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                ST_SHIFT: begin
                    if (r_cnt != c_div_last) begin
                        r_cnt <= r_cnt + 1'b1;
                    end else begin
                        r_cnt <= '0;
                        if (spi_sclk) begin
                            spi_sclk <= 1'b0;
                            if (r_bit != c_bit_last) begin
                                spi_mosi <= r_tx[DATA_W-2];
                                r_tx     <= r_tx << 1;
                            end
                        end else if (r_bit == c_bit_last) begin
                            r_state <= ST_HOLD;
                        end else begin
                            spi_sclk <= 1'b1;
                            r_bit    <= r_bit + 1'b1;
                            r_rx     <= {r_rx[DATA_W-2:0], spi_miso};
                        end
                    end
                end

                ST_HOLD: begin
                    if (r_cnt == c_div_last) begin
                        r_cnt    <= '0;
                        spi_ss_n <= 1'b1;
                        spi_mosi <= 1'b0;
                        grant    <= 2'b00;
                        if (r_owner) begin
                            rdata1 <= r_rx;
                            done1  <= 1'b1;
                        end else begin
                            rdata0 <= r_rx;
                            done0  <= 1'b1;
                        end
                        if (CS_GAP > 1) begin
                            r_state <= ST_GAP;
                        end else begin
                            r_state <= ST_IDLE;
                            busy    <= 1'b0;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                ST_GAP: begin
                    if (r_cnt == c_gap_last) begin
                        r_cnt   <= '0;
                        busy    <= 1'b0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    a_grant_onehot0: assert property (@(posedge clk) disable iff (reset) $onehot0(grant));
    a_done_exclusive: assert property (@(posedge clk) disable iff (reset) !(done0 && done1));
    a_busy_state: assert property (@(posedge clk) disable iff (reset)
        ((r_state == ST_IDLE) == !busy));
    a_gap_no_grant: assert property (@(posedge clk) disable iff (reset)
        ((r_state == ST_GAP) |-> (grant == 2'b00)));

endmodule
`default_nettype wire

// File: tb/tb_spi_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_bus_arbiter
// Purpose  : Directed self-checking bench for spi_bus_arbiter with an SPI
//            mode-0 slave model per instance.
// Revision : 1.0
// ============================================================================
module tb_spi_bus_arbiter;

    localparam int c_dw  = 8;
    localparam int c_cd  = 2;
    localparam int c_gap = 2;
    localparam int c_dwb = 32;
    localparam int c_cdb = 1;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    logic            req0 = 1'b0, req1 = 1'b0;
    logic [c_dw-1:0] wdata0 = '0, wdata1 = '0;
    logic            done0, done1, busy, spi_sclk, spi_mosi, spi_ss_n;
    logic [c_dw-1:0] rdata0, rdata1;
    logic [1:0]      grant;
    logic            spi_miso = 1'b0;

    logic             b_req0 = 1'b0, b_req1 = 1'b0;
    logic [c_dwb-1:0] b_wdata0 = '0, b_wdata1 = '0;
    logic             b_done0, b_done1, b_busy, b_spi_sclk, b_spi_mosi, b_spi_ss_n;
    logic [c_dwb-1:0] b_rdata0, b_rdata1;
    logic [1:0]       b_grant;
    logic             b_spi_miso = 1'b0;

    spi_bus_arbiter #(.DATA_W(c_dw), .CLK_DIV(c_cd), .CS_GAP(c_gap)) u_dut (
        .clk(clk), .reset(reset), .req0(req0), .req1(req1),
        .wdata0(wdata0), .wdata1(wdata1), .done0(done0), .done1(done1),
        .rdata0(rdata0), .rdata1(rdata1), .grant(grant), .busy(busy),
        .spi_sclk(spi_sclk), .spi_mosi(spi_mosi), .spi_ss_n(spi_ss_n),
        .spi_miso(spi_miso)
    );

    spi_bus_arbiter #(.DATA_W(c_dwb), .CLK_DIV(c_cdb), .CS_GAP(c_gap)) u_dut_b (
        .clk(clk), .reset(reset), .req0(b_req0), .req1(b_req1),
        .wdata0(b_wdata0), .wdata1(b_wdata1), .done0(b_done0), .done1(b_done1),
        .rdata0(b_rdata0), .rdata1(b_rdata1), .grant(b_grant), .busy(b_busy),
        .spi_sclk(b_spi_sclk), .spi_mosi(b_spi_mosi), .spi_ss_n(b_spi_ss_n),
        .spi_miso(b_spi_miso)
    );

    initial forever #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int qget(input int q[$], input int i);
        if (i >= 0 && i < q.size()) return q[i];
        return -1;
    endfunction

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Slave model and event recorder for the 8-bit instance.
    logic [c_dw-1:0] slv_tx0 = '0, slv_tx1 = '0, a_cur, mosi_cap = '0;
    logic [1:0]      prev_grant = 2'b00;
    logic            prev_sclk = 1'b0, prev_ss = 1'b1;
    int a_idx = 0, rise_cnt = 0, ss_high_run = 0, bad_onehot = 0, bad_overlap = 0;
    int q_gcyc[$], q_gval[$], q_dcyc[$], q_did[$], q_mosi[$], q_gap[$];

    always @(negedge clk) begin
        if (grant == 2'b11) bad_onehot++;
        if (done0 && done1) bad_overlap++;
        if (prev_grant == 2'b00 && grant != 2'b00) begin
            q_gcyc.push_back(cyc);
            q_gval.push_back(int'(grant));
        end
        if (done0) begin q_dcyc.push_back(cyc); q_did.push_back(0); end
        if (done1) begin q_dcyc.push_back(cyc); q_did.push_back(1); end
        if (spi_ss_n) begin
            if (!prev_ss) q_mosi.push_back(int'(mosi_cap));
            ss_high_run++;
            a_idx = 0;
        end else begin
            if (prev_ss) begin
                q_gap.push_back(ss_high_run);
                ss_high_run = 0;
            end
            if (spi_sclk && !prev_sclk) begin
                mosi_cap = {mosi_cap[c_dw-2:0], spi_mosi};
                a_idx++;
                rise_cnt++;
            end
        end
        a_cur    = grant[1] ? slv_tx1 : slv_tx0;
        spi_miso = (!spi_ss_n && a_idx < c_dw) ? a_cur[c_dw-1-a_idx] : 1'b0;
        prev_grant = grant;
        prev_sclk  = spi_sclk;
        prev_ss    = spi_ss_n;
    end

    // Slave model and event recorder for the 32-bit, CLK_DIV=1 instance.
    logic [c_dwb-1:0] b_slv_tx = '0, b_mosi_cap = '0;
    logic             b_prev_sclk = 1'b0;
    logic [1:0]       b_prev_grant = 2'b00;
    int b_idx = 0, b_rise_cnt = 0, b_first_rise = -1, b_last_rise = -1;
    int b_gcyc = -1, b_dcyc = -1, b_done0_cnt = 0, b_done1_cnt = 0;

    always @(negedge clk) begin
        if (b_prev_grant == 2'b00 && b_grant != 2'b00) b_gcyc = cyc;
        if (b_done0) begin b_dcyc = cyc; b_done0_cnt++; end
        if (b_done1) b_done1_cnt++;
        if (b_spi_ss_n) begin
            b_idx = 0;
        end else if (b_spi_sclk && !b_prev_sclk) begin
            if (b_rise_cnt == 0) b_first_rise = cyc;
            b_last_rise = cyc;
            b_rise_cnt++;
            b_mosi_cap = {b_mosi_cap[c_dwb-2:0], b_spi_mosi};
            b_idx++;
        end
        b_spi_miso   = (!b_spi_ss_n && b_idx < c_dwb) ? b_slv_tx[c_dwb-1-b_idx] : 1'b0;
        b_prev_sclk  = b_spi_sclk;
        b_prev_grant = b_grant;
    end

    task automatic clear_log();
        q_gcyc.delete(); q_gval.delete(); q_dcyc.delete();
        q_did.delete();  q_mosi.delete(); q_gap.delete();
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    int base;

    initial begin
        // Reset values while reset is held high
        repeat (4) @(negedge clk);
        check_value("rst_grant",  grant,    2'b00);
        check_value("rst_busy",   busy,     1'b0);
        check_value("rst_done",   {done0, done1}, 2'b00);
        check_value("rst_rdata",  {rdata0, rdata1}, 16'h0000);
        check_value("rst_ss_n",   spi_ss_n, 1'b1);
        check_value("rst_sclk",   spi_sclk, 1'b0);
        check_value("rst_mosi",   spi_mosi, 1'b0);
        reset = 1'b0;
        @(negedge clk);

        // Single frame from requester 0
        clear_log();
        wdata0 = 8'hA5; slv_tx0 = 8'h3C;
        req0 = 1'b1;
        @(negedge clk);
        req0 = 1'b0;
        check_value("f1_grant",  grant,    2'b01);
        check_value("f1_busy",   busy,     1'b1);
        check_value("f1_ss_n",   spi_ss_n, 1'b0);
        check_value("f1_mosi0",  spi_mosi, 1'b1);
        repeat (50) @(negedge clk);
        check_value("f1_ndone",   q_did.size(), 1);
        check_value("f1_done_id", qget(q_did, 0), 0);
        check_value("f1_latency", qget(q_dcyc, 0) - qget(q_gcyc, 0), 36);
        check_value("f1_mosi",    qget(q_mosi, 0), 8'hA5);
        check_value("f1_rdata0",  rdata0, 8'h3C);
        check_value("f1_rdata1",  rdata1, 8'h00);
        check_value("f1_ngrant",  q_gval.size(), 1);
        check_value("f1_idle",    {busy, grant, spi_ss_n}, 4'b0001);

        // Both requesters held for six frames after a fresh reset
        pulse_reset();
        clear_log();
        wdata0 = 8'hC3; wdata1 = 8'h5A; slv_tx0 = 8'h81; slv_tx1 = 8'h7E;
        req0 = 1'b1; req1 = 1'b1;
        for (int t = 0; t < 400 && q_did.size() < 6; t++) @(negedge clk);
        req0 = 1'b0; req1 = 1'b0;
        repeat (60) @(negedge clk);
        check_value("rr_ndone",  q_did.size(), 6);
        check_value("rr_ngrant", q_gval.size(), 6);
        for (int i = 0; i < 6; i++) begin
            check_value($sformatf("rr_grant%0d", i), qget(q_gval, i), (i % 2 == 0) ? 1 : 2);
            check_value($sformatf("rr_done_id%0d", i), qget(q_did, i), i % 2);
            check_value($sformatf("rr_lat%0d", i), qget(q_dcyc, i) - qget(q_gcyc, i), 36);
            check_value($sformatf("rr_mosi%0d", i), qget(q_mosi, i), (i % 2 == 0) ? 8'hC3 : 8'h5A);
        end
        for (int i = 1; i < 6; i++) begin
            check_value($sformatf("rr_period%0d", i), qget(q_gcyc, i) - qget(q_gcyc, i - 1), 38);
            check_value($sformatf("rr_ss_gap%0d", i), qget(q_gap, i), 2);
        end
        check_value("rr_rdata0",  rdata0, 8'h81);
        check_value("rr_rdata1",  rdata1, 8'h7E);
        check_value("rr_overlap", bad_overlap, 0);
        check_value("rr_onehot",  bad_onehot, 0);

        // Requester 1 drops its request mid-frame
        pulse_reset();
        clear_log();
        wdata1 = 8'h4B; slv_tx1 = 8'hD2;
        req1 = 1'b1;
        base = rise_cnt;
        for (int t = 0; t < 200 && rise_cnt < base + 3; t++) @(negedge clk);
        req1 = 1'b0;
        repeat (80) @(negedge clk);
        check_value("drop_ngrant", q_gval.size(), 1);
        check_value("drop_grant",  qget(q_gval, 0), 2);
        check_value("drop_ndone",  q_did.size(), 1);
        check_value("drop_id",     qget(q_did, 0), 1);
        check_value("drop_lat",    qget(q_dcyc, 0) - qget(q_gcyc, 0), 36);
        check_value("drop_mosi",   qget(q_mosi, 0), 8'h4B);
        check_value("drop_rdata1", rdata1, 8'hD2);
        check_value("drop_rdata0", rdata0, 8'h00);

        // Reset at the fifth SCLK rise aborts the frame
        clear_log();
        wdata0 = 8'hE7; slv_tx0 = 8'h18;
        req0 = 1'b1;
        @(negedge clk);
        req0 = 1'b0;
        base = rise_cnt;
        for (int t = 0; t < 200 && rise_cnt < base + 5; t++) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_value("abort_ss_n",  spi_ss_n, 1'b1);
        check_value("abort_sclk",  spi_sclk, 1'b0);
        check_value("abort_grant", grant,    2'b00);
        check_value("abort_done",  {done0, done1}, 2'b00);
        check_value("abort_rdata1", rdata1, 8'h00);
        reset = 1'b0;
        repeat (60) @(negedge clk);
        check_value("abort_ndone", q_did.size(), 0);
        clear_log();
        wdata0 = 8'h96; slv_tx0 = 8'h69;
        req0 = 1'b1;
        @(negedge clk);
        req0 = 1'b0;
        repeat (50) @(negedge clk);
        check_value("post_ndone",  q_did.size(), 1);
        check_value("post_lat",    qget(q_dcyc, 0) - qget(q_gcyc, 0), 36);
        check_value("post_mosi",   qget(q_mosi, 0), 8'h96);
        check_value("post_rdata0", rdata0, 8'h69);

        // 32-bit frame with CLK_DIV=1
        b_wdata0 = 32'h1234_5678; b_slv_tx = 32'hCAFE_F00D;
        b_req0 = 1'b1;
        @(negedge clk);
        b_req0 = 1'b0;
        repeat (90) @(negedge clk);
        check_value("b_rises",   b_rise_cnt, 32);
        check_value("b_span",    b_last_rise - b_first_rise, 62);
        check_value("b_lat",     b_dcyc - b_gcyc, 66);
        check_value("b_ndone0",  b_done0_cnt, 1);
        check_value("b_ndone1",  b_done1_cnt, 0);
        check_value("b_mosi",    b_mosi_cap, 32'h1234_5678);
        check_value("b_rdata0",  b_rdata0, 32'hCAFE_F00D);
        check_value("b_rdata1",  b_rdata1, 32'h0000_0000);
        check_value("b_idle",    {b_busy, b_grant, b_spi_ss_n, b_spi_sclk}, 5'b00010);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
